// File: rtl/output_bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : output_bp_pkg
// Description : Shared types and width helpers for the output-layer backprop
//               sequencer and its update datapath.
//               - bp_state_t : sequencer state encoding
//               - err_width  : width of the signed error term
//               - grad_width : width of the signed gradient
//               - sat_max / sat_min : clamp bounds for a W_W-bit signed weight
//               - addr_width : index width for N entries (minimum 1)
// Revision    : 1.0 - initial release
// ============================================================================
package output_bp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_CLR  = 3'd3,
        ST_FIN  = 3'd4
    } bp_state_t;

    // One extra bit so the difference of two zero-extended values stays signed.
    function automatic int err_width(input int x_w, input int y_w);
        return ((x_w > y_w) ? x_w : y_w) + 1;
    endfunction

    // err * h needs E+H+1 bits with h zero-extended; the factor 2 adds one more.
    function automatic int grad_width(input int e_w, input int h_w);
        return e_w + h_w + 2;
    endfunction

    function automatic int sat_max(input int w_w);
        return (1 << (w_w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w_w);
        return -(1 << (w_w - 1));
    endfunction

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/output_bp_update_dp.sv
`default_nettype none
// ============================================================================
// Module      : output_bp_update_dp
// Description : Combinational SGD weight update with signed saturation.
//               w_new = clamp(sext(w) - ((2*err*h) >>> LR_SHIFT))
// Ports       : err_i   in  E_W  signed error term
//               h_i     in  H_W  unsigned activation
//               w_i     in  W_W  signed current weight
//               w_new_o out W_W  clamped updated weight
//               sat_o   out 1    clamp was applied
// Revision    : 1.0 - initial release
// ============================================================================
module output_bp_update_dp
    import output_bp_pkg::*;
#(
    parameter int E_W      = 24,
    parameter int H_W      = 10,
    parameter int W_W      = 8,
    parameter int LR_SHIFT = 4
) (
    input  logic signed [E_W-1:0] err_i,
    input  logic        [H_W-1:0] h_i,
    input  logic signed [W_W-1:0] w_i,
    output logic        [W_W-1:0] w_new_o,
    output logic                  sat_o
);

    localparam int G_W = grad_width(E_W, H_W);
    // One guard bit so sext(w) - delta cannot overflow before clamping.
    localparam int N_W = G_W + 1;
    localparam logic signed [N_W-1:0] C_MAX = N_W'(sat_max(W_W));
    localparam logic signed [N_W-1:0] C_MIN = N_W'(sat_min(W_W));

    logic signed [G_W-1:0] w_err_x;
    logic signed [G_W-1:0] w_h_x;
    logic signed [G_W-1:0] w_grad;
    logic signed [G_W-1:0] w_delta;
    logic signed [N_W-1:0] w_full;

    assign w_err_x = {{(G_W-E_W){err_i[E_W-1]}}, err_i};
    assign w_h_x   = {{(G_W-H_W){1'b0}}, h_i};
    assign w_grad  = (w_err_x * w_h_x) <<< 1;
    // Arithmetic shift gives floor rounding for negative gradients.
    assign w_delta = w_grad >>> LR_SHIFT;
    assign w_full  = {{(N_W-W_W){w_i[W_W-1]}}, w_i} - {w_delta[G_W-1], w_delta};

    always_comb begin
        w_new_o = w_full[W_W-1:0];
        sat_o   = 1'b0;
        if (w_full > C_MAX) begin
            w_new_o = C_MAX[W_W-1:0];
            sat_o   = 1'b1;
        end else if (w_full < C_MIN) begin
            w_new_o = C_MIN[W_W-1:0];
            sat_o   = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/output_backprop_seq.sv
`default_nettype none
// ============================================================================
// Module      : output_backprop_seq
// Description : Sequential SGD update of all N_HIDDEN output-layer weights,
//               one weight per two cycles (read, then write), using an error
//               term latched at start. Also offers a weight-clear sweep.
// Ports       : clk_i, rst_i (async, active-high)
//               start_i / clear_i       : pass requests, sampled in IDLE only
//               target_i, final_i       : error operands, latched on start
//               h_addr_o / h_val_i      : hidden value read port
//               w_addr_o / w_rd_i       : weight read port (same address as write)
//               w_wr_en_o / w_wr_data_o : weight write port
//               busy_o, done_o, sat_o   : status
// Revision    : 1.0 - initial release
// ============================================================================
module output_backprop_seq
    import output_bp_pkg::*;
#(
    parameter int N_HIDDEN = 4,
    parameter int X_W      = 4,
    parameter int Y_W      = 23,
    parameter int H_W      = 10,
    parameter int W_W      = 8,
    parameter int LR_SHIFT = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic                              clear_i,
    input  logic [X_W-1:0]                    target_i,
    input  logic [Y_W-1:0]                    final_i,
    output logic [addr_width(N_HIDDEN)-1:0]   h_addr_o,
    input  logic [H_W-1:0]                    h_val_i,
    output logic [addr_width(N_HIDDEN)-1:0]   w_addr_o,
    input  logic [W_W-1:0]                    w_rd_i,
    output logic                              w_wr_en_o,
    output logic [W_W-1:0]                    w_wr_data_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              sat_o
);

    localparam int E_W = err_width(X_W, Y_W);
    localparam int A_W = addr_width(N_HIDDEN);
    localparam logic [A_W-1:0] C_LAST = A_W'(N_HIDDEN - 1);

    bp_state_t             r_state;
    logic [A_W-1:0]        r_k;
    logic signed [E_W-1:0] r_err;
    logic [H_W-1:0]        r_h;
    logic signed [W_W-1:0] r_w;
    logic                  r_sat;

    logic [W_W-1:0]        w_new;
    logic                  w_clamp;

    // Update computed from the operands captured in RD, so the write data in
    // WR does not depend on the register-file read path.
    output_bp_update_dp #(
        .E_W      (E_W),
        .H_W      (H_W),
        .W_W      (W_W),
        .LR_SHIFT (LR_SHIFT)
    ) u_dp (
        .err_i   (r_err),
        .h_i     (r_h),
        .w_i     (r_w),
        .w_new_o (w_new),
        .sat_o   (w_clamp)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_err   <= '0;
            r_h     <= '0;
            r_w     <= '0;
            r_sat   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_k <= '0;
                    if (clear_i) begin
                        r_state <= ST_CLR;
                    end else if (start_i) begin
                        r_err   <= $signed({{(E_W-Y_W){1'b0}}, final_i})
                                 - $signed({{(E_W-X_W){1'b0}}, target_i});
                        r_sat   <= 1'b0;
                        r_state <= ST_RD;
                    end
                end
                ST_RD: begin
                    r_h     <= h_val_i;
                    r_w     <= w_rd_i;
                    r_state <= ST_WR;
                end
                ST_WR: begin
                    if (w_clamp) begin
                        r_sat <= 1'b1;
                    end
                    if (r_k == C_LAST) begin
                        r_state <= ST_FIN;
                    end else begin
                        r_k     <= r_k + 1'b1;
                        r_state <= ST_RD;
                    end
                end
                ST_CLR: begin
                    if (r_k == C_LAST) begin
                        r_state <= ST_FIN;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                ST_FIN: begin
                    // k returns to 0 so the address outputs idle at 0.
                    r_k     <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded purely from registers; asynchronous reset forces
    // them to 0 immediately.
    assign h_addr_o    = r_k;
    assign w_addr_o    = r_k;
    assign w_wr_en_o   = (r_state == ST_WR) || (r_state == ST_CLR);
    assign w_wr_data_o = (r_state == ST_WR) ? w_new : '0;
    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = (r_state == ST_FIN);
    assign sat_o       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_output_backprop_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_backprop_seq
// Description : Self-checking bench for output_backprop_seq. Expected weight
//               writes are queued when a pass is issued; a monitor pops and
//               compares on every write strobe. Register files are modelled
//               here with combinational reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_backprop_seq;

    localparam int N       = 4;
    localparam int X_W     = 4;
    localparam int Y_W     = 23;
    localparam int H_W     = 10;
    localparam int W_W     = 8;
    localparam int LR      = 4;
    localparam int AW      = 2;
    localparam int CYC_UPD = 2 * N + 1;
    localparam int CYC_CLR = N + 1;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic           start_i = 1'b0;
    logic           clear_i = 1'b0;
    logic [X_W-1:0] target_i = '0;
    logic [Y_W-1:0] final_i = '0;
    logic [AW-1:0]  h_addr_o;
    logic [AW-1:0]  w_addr_o;
    logic [H_W-1:0] h_val_i;
    logic [W_W-1:0] w_rd_i;
    logic           w_wr_en_o;
    logic [W_W-1:0] w_wr_data_o;
    logic           busy_o;
    logic           done_o;
    logic           sat_o;

    always #5 clk = ~clk;

    output_backprop_seq #(
        .N_HIDDEN (N), .X_W (X_W), .Y_W (Y_W), .H_W (H_W), .W_W (W_W), .LR_SHIFT (LR)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .clear_i     (clear_i),
        .target_i    (target_i),
        .final_i     (final_i),
        .h_addr_o    (h_addr_o),
        .h_val_i     (h_val_i),
        .w_addr_o    (w_addr_o),
        .w_rd_i      (w_rd_i),
        .w_wr_en_o   (w_wr_en_o),
        .w_wr_data_o (w_wr_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .sat_o       (sat_o)
    );

    // Environment register files
    logic [W_W-1:0] wmem [N];
    logic [H_W-1:0] hmem [N];
    logic           bd_load = 1'b0;
    logic [W_W-1:0] bd_vals [N];

    assign w_rd_i  = wmem[w_addr_o];
    assign h_val_i = hmem[h_addr_o];

    always @(posedge clk) begin
        if (w_wr_en_o)
            wmem[w_addr_o] <= w_wr_data_o;
        else if (bd_load)
            for (int i = 0; i < N; i++) wmem[i] <= bd_vals[i];
    end

    typedef struct { int addr; longint data; } wr_t;
    wr_t    exp_q[$];
    int     total = 0;
    int     bad = 0;
    int     wr_count = 0;
    longint mw [N];
    bit     exp_sat = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer SGD step with floor division and clamping.
    function automatic longint ref_w(input longint w, input longint h, input longint tgt,
                                     input longint fin, output bit clamp);
        longint err, grad, d, delta, nw;
        err  = fin - tgt;
        grad = 2 * err * h;
        d    = longint'(1) << LR;
        if (grad >= 0) delta = grad / d;
        else           delta = -((-grad + d - 1) / d);
        nw    = w - delta;
        clamp = 1'b0;
        if (nw > 127)  begin nw = 127;  clamp = 1'b1; end
        if (nw < -128) begin nw = -128; clamp = 1'b1; end
        return nw;
    endfunction

    // Monitor: every write strobe must match the head of the queue.
    always @(negedge clk) begin
        if (!rst_i && w_wr_en_o) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", longint'(w_addr_o), longint'(e.addr));
                check("wr_data", longint'($signed(w_wr_data_o)), e.data);
            end
        end
    end

    task automatic push_pass(input bit clr, input int tgt, input int fin);
        bit any, c;
        longint nw;
        wr_t e;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (clr) nw = 0;
            else begin
                nw  = ref_w(mw[k], longint'(hmem[k]), longint'(tgt), longint'(fin), c);
                any = any | c;
            end
            mw[k]  = nw;
            e.addr = k;
            e.data = nw;
            exp_q.push_back(e);
        end
        if (!clr) exp_sat = any;
    endtask

    task automatic load_w(input int v [N]);
        for (int i = 0; i < N; i++) begin
            bd_vals[i] = W_W'(v[i]);
            mw[i]      = longint'(v[i]);
        end
        bd_load = 1'b1;
        @(negedge clk);
        bd_load = 1'b0;
    endtask

    task automatic wait_done(input int c0, input int exp, input string name);
        int cyc;
        cyc = c0;
        while (!done_o && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check(name, cyc, exp);
    endtask

    task automatic finish_pass(input string name);
        check({name, "_sat"}, longint'(sat_o), longint'(exp_sat));
        @(negedge clk);
        check({name, "_done_pulse"}, longint'(done_o), 0);
        check({name, "_idle"}, longint'(busy_o), 0);
        check({name, "_queue"}, exp_q.size(), 0);
        for (int k = 0; k < N; k++)
            check({name, "_mem"}, longint'($signed(wmem[k])), mw[k]);
    endtask

    // Issues a pass from IDLE at a negedge and runs it to completion.
    task automatic run_pass(input bit clr, input bit st, input int tgt, input int fin,
                            input bit pulse, input string name);
        bit sat_before;
        sat_before = exp_sat;
        push_pass(clr, tgt, fin);
        target_i = X_W'(tgt);
        final_i  = Y_W'(fin);
        start_i  = st;
        clear_i  = clr;
        @(negedge clk);
        start_i = 1'b0;
        clear_i = 1'b0;
        check({name, "_busy"}, longint'(busy_o), 1);
        check({name, "_sat_start"}, longint'(sat_o), clr ? longint'(sat_before) : 0);
        if (pulse) begin
            // Mid-pass requests and operand changes must have no effect.
            @(negedge clk); start_i = 1'b1; target_i = ~target_i;
            @(negedge clk); start_i = 1'b0; clear_i = 1'b1; final_i = ~final_i;
            @(negedge clk); clear_i = 1'b0;
            wait_done(4, clr ? CYC_CLR : CYC_UPD, {name, "_done_cyc"});
        end else begin
            wait_done(1, clr ? CYC_CLR : CYC_UPD, {name, "_done_cyc"});
        end
        finish_pass(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, f, cnt0;
        longint pre [N];
        for (int i = 0; i < N; i++) begin hmem[i] = '0; wmem[i] = '0; mw[i] = 0; end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",  longint'(busy_o), 0);
        check("rst_done",  longint'(done_o), 0);
        check("rst_wr_en", longint'(w_wr_en_o), 0);
        check("rst_wdata", longint'(w_wr_data_o), 0);
        check("rst_sat",   longint'(sat_o), 0);
        check("rst_waddr", longint'(w_addr_o), 0);
        check("rst_haddr", longint'(h_addr_o), 0);
        rst_i = 1'b0;
        @(negedge clk);

        // Basic update
        hmem = '{10, 7, 100, 50};
        load_w('{5, -3, 20, 0});
        run_pass(0, 1, 3, 1, 0, "basic");

        // Positive error, all weights
        hmem = '{1, 2, 3, 4};
        load_w('{0, 0, 0, 0});
        run_pass(0, 1, 0, 4, 0, "poserr");

        // Saturation high and low
        hmem = '{1023, 0, 0, 0};
        load_w('{120, 0, 0, 0});
        run_pass(0, 1, 15, 0, 0, "sat_pos");
        load_w('{-100, 0, 0, 0});
        run_pass(0, 1, 0, 1000, 0, "sat_neg");

        // Clear wins over start; sat flag preserved
        hmem = '{5, 6, 7, 8};
        load_w('{11, -22, 33, -44});
        run_pass(1, 1, 0, 0, 0, "clear");

        // start_i held high: two back-to-back passes, then nothing
        load_w('{1, 2, 3, 4});
        cnt0 = wr_count;
        push_pass(0, 2, 9);
        target_i = 2; final_i = 9; start_i = 1'b1;
        @(negedge clk);
        wait_done(1, CYC_UPD, "hold_p1_done");
        check("hold_p1_sat", longint'(sat_o), longint'(exp_sat));
        push_pass(0, 2, 9);
        @(negedge clk);
        check("hold_gap_idle", longint'(busy_o), 0);
        @(negedge clk);
        check("hold_p2_start", longint'(busy_o), 1);
        start_i = 1'b0;
        wait_done(1, CYC_UPD, "hold_p2_done");
        finish_pass("hold");
        repeat (3) begin
            @(negedge clk);
            check("hold_no_third", longint'(busy_o), 0);
        end
        check("hold_writes", wr_count - cnt0, 2 * N);

        // Requests while busy are ignored
        hmem = '{300, 200, 100, 0};
        load_w('{-7, 7, -70, 70});
        run_pass(0, 1, 6, 12, 1, "busy_pulse");
        run_pass(1, 0, 0, 0, 1, "busy_pulse_clr");

        // Asynchronous reset during the second WR
        hmem = '{9, 19, 29, 39};
        load_w('{10, 20, 30, 40});
        for (int i = 0; i < N; i++) pre[i] = mw[i];
        push_pass(0, 1, 8);
        target_i = 1; final_i = 8; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;     // RD k0
        @(negedge clk);                     // WR k0
        @(negedge clk);                     // RD k1
        @(posedge clk);                     // into WR k1
        #1 rst_i = 1'b1;
        #1;
        check("arst_wr_en", longint'(w_wr_en_o), 0);
        check("arst_busy",  longint'(busy_o), 0);
        check("arst_waddr", longint'(w_addr_o), 0);
        check("arst_wdata", longint'(w_wr_data_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        exp_q.delete();
        for (int i = 1; i < N; i++) mw[i] = pre[i];
        exp_sat = 1'b0;
        for (int k = 0; k < N; k++)
            check("arst_mem", longint'($signed(wmem[k])), mw[k]);
        check("arst_sat", longint'(sat_o), 0);
        @(negedge clk);
        run_pass(0, 1, 4, 2, 0, "after_rst");

        // Randomized passes
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < N; i++) hmem[i] = H_W'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) == 0)
                load_w('{int'($signed(8'($urandom))), int'($signed(8'($urandom))),
                         int'($signed(8'($urandom))), int'($signed(8'($urandom)))});
            t = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) f = int'($urandom_range(0, 40));
            else                           f = int'($urandom_range(0, (1 << Y_W) - 1));
            if ($urandom_range(0, 4) == 0)
                run_pass(1, 1'($urandom_range(0, 1)), t, f, 0, "rnd_clr");
            else
                run_pass(0, 1, t, f, 1'($urandom_range(0, 1)), "rnd_upd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
